// File: rtl/video_in_pkg.sv
// Shared types and defaults for the video input DMA controller.
// States, the Wishbone byte-select constant and default geometry.
package video_in_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } state_e;

   localparam logic [3:0] WB_SEL_ALL      = 4'hF;
   localparam int         BURST_LEN_DEF   = 8;
   localparam int         FRAME_WORDS_DEF = 76800;

endpackage

// File: rtl/video_in_addr_gen.sv
// Frame address generator: write pointer, frame word counter, active/pending base swap.
// Flags frame end combinationally on the acknowledgment that completes the frame.
module video_in_addr_gen
   import video_in_pkg::*;
#(
   parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        cfg_vld,
   input  logic [31:0] cfg_base,
   input  logic        arm,
   input  logic        adv,
   output logic [31:0] ptr,
   output logic        frame_end,
   output logic        pending_valid
);

   localparam int CW = $clog2(FRAME_WORDS + 1);

   logic [31:0] ptr_q, ptr_d;
   logic [31:0] active_base_q, active_base_d;
   logic [31:0] pending_base_q, pending_base_d;
   logic        pending_valid_q, pending_valid_d;
   logic [CW-1:0] frame_cnt_q, frame_cnt_d;

   always_comb begin
      ptr_d           = ptr_q;
      active_base_d   = active_base_q;
      pending_base_d  = pending_base_q;
      pending_valid_d = pending_valid_q;
      frame_cnt_d     = frame_cnt_q;
      frame_end       = adv && (frame_cnt_q == CW'(FRAME_WORDS - 1));

      if (arm) begin
         active_base_d   = pending_base_q;
         ptr_d           = pending_base_q;
         pending_valid_d = 1'b0;
         frame_cnt_d     = '0;
      end else if (frame_end) begin
         frame_cnt_d = '0;
         if (pending_valid_q) begin
            active_base_d   = pending_base_q;
            ptr_d           = pending_base_q;
            pending_valid_d = 1'b0;
         end else begin
            ptr_d = active_base_q;
         end
      end else if (adv) begin
         ptr_d       = ptr_q + 32'd4;
         frame_cnt_d = frame_cnt_q + 1'b1;
      end

      // A new base lands after any swap, so a coincident write becomes the next pending base.
      if (cfg_vld) begin
         pending_base_d  = cfg_base;
         pending_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         ptr_q           <= '0;
         active_base_q   <= '0;
         pending_base_q  <= '0;
         pending_valid_q <= 1'b0;
         frame_cnt_q     <= '0;
      end else begin
         ptr_q           <= ptr_d;
         active_base_q   <= active_base_d;
         pending_base_q  <= pending_base_d;
         pending_valid_q <= pending_valid_d;
         frame_cnt_q     <= frame_cnt_d;
      end
   end

   assign ptr           = ptr_q;
   assign pending_valid = pending_valid_q;

endmodule

// File: rtl/video_in_dma_ctrl.sv
// Video input DMA: moves FIFO packs of BURST_LEN words to memory as Wishbone bursts.
// Optional VIDEO_IN_ERR_ABORT_EN: ERR_I ends the bus cycle and the pack resumes later.
module video_in_dma_ctrl
   import video_in_pkg::*;
#(
   parameter int BURST_LEN   = BURST_LEN_DEF,
   parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        nb_pack_available,
   input  logic [31:0] data_fifo,
   output logic        r_ack,
   input  logic [31:0] wb_reg_data,
   input  logic        wb_reg_ctr,
   output logic        interrupt,
   output logic        p_wb_STB_O,
   output logic        p_wb_CYC_O,
   output logic        p_wb_LOCK_O,
   output logic [3:0]  p_wb_SEL_O,
   output logic [31:0] p_wb_ADR_O,
   output logic [31:0] p_wb_DAT_O,
   input  logic        p_wb_ACK_I,
   input  logic        p_wb_ERR_I
);

   localparam int BW = $clog2(BURST_LEN + 1);

   if (BURST_LEN < 1) begin : g_chk_len
      $fatal(1, "video_in_dma_ctrl: BURST_LEN must be at least 1");
   end else if ((FRAME_WORDS % BURST_LEN) != 0) begin : g_chk_frame
      $fatal(1, "video_in_dma_ctrl: FRAME_WORDS must be a multiple of BURST_LEN");
   end

   state_e        state_q, state_d;
   logic [BW-1:0] burst_cnt_q, burst_cnt_d;
   logic          interrupt_q, interrupt_d;
   logic          arm;
   logic          word_ack;
   logic          frame_end;
   logic          pending_valid;
   logic [31:0]   ptr;

   assign word_ack = (state_q == BURST) && (p_wb_ACK_I || p_wb_ERR_I);

   video_in_addr_gen #(
      .FRAME_WORDS (FRAME_WORDS)
   ) u_addr_gen (
      .clk           (clk),
      .RST           (RST),
      .cfg_vld       (wb_reg_ctr),
      .cfg_base      (wb_reg_data & 32'hFFFF_FFFC),
      .arm           (arm),
      .adv           (word_ack),
      .ptr           (ptr),
      .frame_end     (frame_end),
      .pending_valid (pending_valid)
   );

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      interrupt_d = 1'b0;
      arm         = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (pending_valid) begin
               arm     = 1'b1;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (nb_pack_available) begin
               state_d = BURST;
            end
         end
         BURST: begin
            if (word_ack) begin
               if (frame_end || (burst_cnt_q == BW'(BURST_LEN - 1))) begin
                  state_d     = WAIT;
                  burst_cnt_d = '0;
                  interrupt_d = frame_end;
               end else begin
                  // The count survives an aborted cycle so the resumed cycle finishes the pack.
                  burst_cnt_d = burst_cnt_q + 1'b1;
`ifdef VIDEO_IN_ERR_ABORT_EN
                  if (p_wb_ERR_I) begin
                     state_d = WAIT;
                  end
`endif
               end
            end
         end
         default: begin
            state_d     = IDLE;
            burst_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         burst_cnt_q <= '0;
         interrupt_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         interrupt_q <= interrupt_d;
      end
   end

   always_comb begin
      p_wb_CYC_O  = 1'b0;
      p_wb_STB_O  = 1'b0;
      p_wb_LOCK_O = 1'b0;
      p_wb_SEL_O  = 4'h0;
      p_wb_ADR_O  = 32'h0;
      p_wb_DAT_O  = 32'h0;
      if (state_q == BURST) begin
         p_wb_CYC_O  = 1'b1;
         p_wb_STB_O  = 1'b1;
         p_wb_LOCK_O = 1'b1;
         p_wb_SEL_O  = WB_SEL_ALL;
         p_wb_ADR_O  = ptr;
         p_wb_DAT_O  = data_fifo;
      end
   end

   assign r_ack     = word_ack;
   assign interrupt = interrupt_q;

endmodule

// File: tb/tb_video_in_dma_ctrl.sv
// Directed bench for video_in_dma_ctrl with FRAME_WORDS=16, BURST_LEN=8.
// A frame-level model is compared against the bus every cycle, plus literal address checks.
module tb_video_in_dma_ctrl;

   localparam int BL = 8;
   localparam int FW = 16;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        nb = 1'b0;
   logic [31:0] dfifo = 32'h0;
   logic        r_ack;
   logic [31:0] wbd = 32'h0;
   logic        ctr = 1'b0;
   logic        interrupt;
   logic        stb, cyc, lock;
   logic [3:0]  sel;
   logic [31:0] adr, dat;
   logic        ack_i = 1'b0;
   logic        err_i = 1'b0;

   always #5 clk = ~clk;

   video_in_dma_ctrl #(.BURST_LEN(BL), .FRAME_WORDS(FW)) dut (
      .clk               (clk),
      .RST               (RST),
      .nb_pack_available (nb),
      .data_fifo         (dfifo),
      .r_ack             (r_ack),
      .wb_reg_data       (wbd),
      .wb_reg_ctr        (ctr),
      .interrupt         (interrupt),
      .p_wb_STB_O        (stb),
      .p_wb_CYC_O        (cyc),
      .p_wb_LOCK_O       (lock),
      .p_wb_SEL_O        (sel),
      .p_wb_ADR_O        (adr),
      .p_wb_DAT_O        (dat),
      .p_wb_ACK_I        (ack_i),
      .p_wb_ERR_I        (err_i)
   );

   int          checks = 0;
   int          errors = 0;
   int          cyc_n  = 0;
   logic [31:0] ack_adr[$];
   int          ack_cyc[$];
   int          int_cyc[$];

   // Model: 0 = unarmed, 1 = armed/waiting, 2 = bus cycle open
   int          m_st = 0;
   int          m_fidx = 0;
   int          m_bidx = 0;
   logic [31:0] m_active = 32'h0;
   logic [31:0] m_pend = 32'h0;
   logic        m_pend_vld = 1'b0;
   logic        m_int = 1'b0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   initial begin
      logic        busy, ackd;
      logic [72:0] exp_v, act_v;
      forever begin
         @(negedge clk);
         cyc_n++;
         if (RST) begin
            m_st = 0; m_fidx = 0; m_bidx = 0; m_pend_vld = 1'b0; m_int = 1'b0;
         end
         busy  = (m_st == 2);
         exp_v = {busy, busy, busy, busy ? 4'hF : 4'h0,
                  busy ? (m_active + 32'(4 * m_fidx)) : 32'h0,
                  busy ? dfifo : 32'h0,
                  busy && (ack_i || err_i), m_int};
         act_v = {cyc, stb, lock, sel, adr, dat, r_ack, interrupt};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL bus_cycle%0d actual=%h required=%h", cyc_n, act_v, exp_v);
         end
         if (r_ack) begin
            ack_adr.push_back(adr);
            ack_cyc.push_back(cyc_n);
         end
         if (interrupt) int_cyc.push_back(cyc_n);
         if (!RST) begin
            ackd  = busy && (ack_i || err_i);
            m_int = 1'b0;
            case (m_st)
               0: if (m_pend_vld) begin
                     m_active = m_pend; m_fidx = 0; m_pend_vld = 1'b0; m_st = 1;
                  end
               1: if (nb) m_st = 2;
               default: if (ackd) begin
                     m_fidx++;
                     m_bidx++;
                     if (m_fidx == FW) begin
                        m_fidx = 0; m_bidx = 0; m_int = 1'b1; m_st = 1;
                        if (m_pend_vld) begin
                           m_active = m_pend; m_pend_vld = 1'b0;
                        end
                     end else if (m_bidx == BL) begin
                        m_bidx = 0; m_st = 1;
                     end
`ifdef VIDEO_IN_ERR_ABORT_EN
                     else if (err_i) m_st = 1;
`endif
                  end
            endcase
            if (ctr) begin
               m_pend = wbd & 32'hFFFF_FFFC; m_pend_vld = 1'b1;
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1 dfifo = $urandom;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic pulse_ctr(input logic [31:0] v);
      wbd = v; ctr = 1'b1;
      @(posedge clk); #1;
      ctr = 1'b0;
   endtask

   // Acknowledge n words; pack-available is offered whenever no bus cycle is open.
   task automatic ack_words(input int n, input int err_w, input int stall_w,
                            input int ctr_w, input logic [31:0] ctr_v);
      int bud;
      for (int w = 0; w < n; w++) begin
         bud = 0;
         while (!cyc && bud < 40) begin
            nb = 1'b1;
            @(posedge clk); #1;
            bud++;
         end
         nb = 1'b0;
         if (!cyc) begin
            checks++; errors++;
            $display("FAIL cyc_timeout actual=0 required=1");
            return;
         end
         if (w == stall_w) begin
            repeat (3) @(posedge clk);
            #1;
         end
         if (w == err_w) err_i = 1'b1; else ack_i = 1'b1;
         if (w == ctr_w) begin
            wbd = ctr_v; ctr = 1'b1;
         end
         @(posedge clk); #1;
         ack_i = 1'b0; err_i = 1'b0; ctr = 1'b0;
      end
   endtask

   initial begin
      int n, b;
      repeat (3) @(posedge clk);
      #1;
      check32("rst_cyc", {31'h0, cyc}, 32'h0);
      check32("rst_adr", adr, 32'h0);
      check32("rst_int", {31'h0, interrupt}, 32'h0);
      RST = 1'b0;

      // First burst with a three-cycle ACK stall before word 4
      pulse_ctr(32'h0010_0003);
      ack_words(8, -1, 4, -1, 32'h0);
      check32("A_count", 32'(ack_adr.size()), 32'd8);
      for (int i = 0; i < 8; i++) check32("A_adr", ack_adr[i], 32'h0010_0000 + 32'(4 * i));
      check32("A_stall_gap", 32'(ack_cyc[4] - ack_cyc[3]), 32'd4);

      // Reset while the 4th word of the next burst is on the bus
      ack_words(3, -1, -1, -1, 32'h0);
      ack_i = 1'b1;
      RST = 1'b1;
      #1;
      check32("B_cyc_async", {31'h0, cyc}, 32'h0);
      check32("B_rack_async", {31'h0, r_ack}, 32'h0);
      n = ack_adr.size();
      @(posedge clk); #1;
      RST = 1'b0; nb = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      ack_i = 1'b0; nb = 1'b0;
      check32("B_no_rack", 32'(ack_adr.size()), 32'(n));

      // Frame at 0x100 without pending base
      pulse_ctr(32'h0000_0100);
      ack_words(16, -1, -1, -1, 32'h0);
      @(posedge clk); #1;
      check32("C_int_count", 32'(int_cyc.size()), 32'd1);
      check32("C_int_timing", 32'(int_cyc[0]), 32'(ack_cyc[ack_cyc.size() - 1] + 1));
      ack_words(1, -1, -1, -1, 32'h0);
      check32("C_restart", ack_adr[ack_adr.size() - 1], 32'h0000_0100);

      // Pending 0x200 is swapped in at frame end
      pulse_ctr(32'h0000_0200);
      ack_words(15, -1, -1, -1, 32'h0);
      ack_words(1, -1, -1, -1, 32'h0);
      check32("C_swap", ack_adr[ack_adr.size() - 1], 32'h0000_0200);

      // Write coinciding with frame end: old pending swaps, new one waits
      pulse_ctr(32'h0000_0300);
      ack_words(14, -1, -1, -1, 32'h0);
      ack_words(1, -1, -1, 0, 32'h0000_0401);
      ack_words(1, -1, -1, -1, 32'h0);
      check32("D_old_pending", ack_adr[ack_adr.size() - 1], 32'h0000_0300);
      ack_words(15, -1, -1, -1, 32'h0);
      ack_words(1, -1, -1, -1, 32'h0);
      check32("D_new_pending", ack_adr[ack_adr.size() - 1], 32'h0000_0400);
      check32("D_int_count", 32'(int_cyc.size()), 32'd4);

      // ERR_I on word 3 of the burst at 0x420
      ack_words(7, -1, -1, -1, 32'h0);
      b = ack_adr.size();
      ack_words(8, 2, -1, -1, 32'h0);
      check32("E_word3", ack_adr[b + 2], 32'h0000_0428);
      check32("E_word4", ack_adr[b + 3], 32'h0000_042C);
      check32("E_word8", ack_adr[b + 7], 32'h0000_043C);
`ifdef VIDEO_IN_ERR_ABORT_EN
      check32("E_abort_gap", {31'h0, (ack_cyc[b + 3] - ack_cyc[b + 2]) > 1}, 32'h1);
`else
      check32("E_no_gap", 32'(ack_cyc[b + 3] - ack_cyc[b + 2]), 32'd1);
`endif

      repeat (4) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
